// File: rtl/multiport_register_file_pkg.sv
// Shared definitions for the multiport register file: parameter defaults,
// index-width helper and the register index type.
package multiport_register_file_pkg;

    localparam int DEF_NUM_READ  = 4;
    localparam int DEF_NUM_WRITE = 2;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_REGS  = 32;
    localparam bit DEF_BYPASS    = 1'b1;
    localparam bit DEF_TRACE_EN  = 1'b0;

    // Index width for a power-of-two register count; never narrower than one bit.
    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    localparam int DEF_AW = addr_width(DEF_NUM_REGS);

    typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy bits: set by issue-time reservations, cleared by writeback,
// with a new reservation overriding a same-edge writeback.
module reg_scoreboard
    import multiport_register_file_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_READ  = DEF_NUM_READ,
    parameter int NUM_WRITE = DEF_NUM_WRITE,
    parameter bit BYPASS    = DEF_BYPASS,
    parameter int AW        = addr_width(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rsv_en   [NUM_WRITE],
    input  logic [AW-1:0] rsv_addr [NUM_WRITE],
    input  logic          wr_en    [NUM_WRITE],
    input  logic [AW-1:0] wr_addr  [NUM_WRITE],
    input  logic [AW-1:0] rd_addr  [NUM_READ],
    output logic          rd_busy  [NUM_READ]
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // NOTE: blocking assignments in always_comb, starting from a full default,
    // so every path assigns busy_d (no latch) and later statements take priority.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w]) busy_d[wr_addr[w]] = 1'b0;
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (rsv_en[w]) busy_d[rsv_addr[w]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // A same-cycle writeback already delivers the value, so the reader need not stall.
    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            rd_busy[r] = busy_q[rd_addr[r]];
            if (BYPASS) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w] == rd_addr[r])) rd_busy[r] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with constant-zero register 0, optional same-cycle
// write forwarding, per-register busy tracking and an optional write trace.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int NUM_READ  = DEF_NUM_READ,
    parameter int NUM_WRITE = DEF_NUM_WRITE,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter bit BYPASS    = DEF_BYPASS,
    parameter bit TRACE_EN  = DEF_TRACE_EN,
    parameter int AW        = addr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr  [NUM_READ],
    output logic [DATA_W-1:0] rd_data  [NUM_READ],
    output logic              rd_busy  [NUM_READ],
    input  logic              wr_en    [NUM_WRITE],
    input  logic [AW-1:0]     wr_addr  [NUM_WRITE],
    input  logic [DATA_W-1:0] wr_data  [NUM_WRITE],
    input  logic              rsv_en   [NUM_WRITE],
    input  logic [AW-1:0]     rsv_addr [NUM_WRITE],
    input  logic [31:0]       wr_pc    [NUM_WRITE]
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Ports are applied in ascending order so the highest-indexed writer wins.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && (wr_addr[w] != '0)) regs_d[wr_addr[w]] = wr_data[w];
        end
    end

    // NOTE: this array is flops, not RAM, and must clear on reset, so every
    // entry is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            rd_data[r] = regs_q[rd_addr[r]];
            if (BYPASS) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w] == rd_addr[r])) rd_data[r] = wr_data[w];
                end
            end
            if (!rst_n || (rd_addr[r] == '0)) rd_data[r] = '0;
        end
    end

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE),
        .BYPASS    (BYPASS),
        .AW        (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

    // The PC only feeds the trace; fold it here so it is never left dangling.
    logic pc_unused;
    always_comb begin
        pc_unused = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++) pc_unused = pc_unused ^ (^wr_pc[w]);
    end

`ifndef SYNTHESIS
    if (TRACE_EN) begin : g_trace
        logic trace_win [NUM_WRITE];

        // A write is reported only if no higher port hits the same register.
        always_comb begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                trace_win[w] = wr_en[w] && (wr_addr[w] != '0);
                for (int v = w + 1; v < NUM_WRITE; v++) begin
                    if (wr_en[v] && (wr_addr[v] == wr_addr[w])) trace_win[w] = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (trace_win[w]) $display("@%h: $%0d <= %h", wr_pc[w], wr_addr[w], wr_data[w]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// a behavioural register-file model for a forwarding and a non-forwarding instance.
`timescale 1ns/1ps
module tb_multiport_register_file;
    import multiport_register_file_pkg::*;

    localparam int NR = 4;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    reg_idx_t    rd_addr  [NR];
    logic [31:0] rd_data_b [NR];
    logic [31:0] rd_data_n [NR];
    logic        rd_busy_b [NR];
    logic        rd_busy_n [NR];
    logic        wr_en    [NW];
    reg_idx_t    wr_addr  [NW];
    logic [31:0] wr_data  [NW];
    logic        rsv_en   [NW];
    reg_idx_t    rsv_addr [NW];
    logic [31:0] wr_pc    [NW];

    logic [31:0] mdl_mem  [32];
    bit          mdl_busy [32];

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    multiport_register_file #(.BYPASS(1'b1), .TRACE_EN(1'b0)) u_dut_byp (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_pc(wr_pc)
    );

    multiport_register_file #(.BYPASS(1'b0), .TRACE_EN(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_pc(wr_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one rising edge.
    task automatic model_edge();
        if (!rst_n) return;
        for (int i = 1; i < 32; i++) begin
            bit hit_wr = 1'b0;
            bit hit_rsv = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (wr_en[w] && wr_addr[w] == reg_idx_t'(i)) begin
                    hit_wr = 1'b1;
                    mdl_mem[i] = wr_data[w];
                end
                if (rsv_en[w] && rsv_addr[w] == reg_idx_t'(i)) hit_rsv = 1'b1;
            end
            if (hit_rsv)     mdl_busy[i] = 1'b1;
            else if (hit_wr) mdl_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_data(input reg_idx_t a, input bit byp);
        logic [31:0] v;
        if (!rst_n || a == 0) return 32'h0;
        v = mdl_mem[a];
        if (byp) begin
            for (int w = 0; w < NW; w++) if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input reg_idx_t a, input bit byp);
        bit fwd = 1'b0;
        if (!rst_n || a == 0) return 1'b0;
        for (int w = 0; w < NW; w++) if (wr_en[w] && wr_addr[w] == a) fwd = 1'b1;
        return mdl_busy[a] && !(byp && fwd);
    endfunction

    task automatic check_all(input string tag);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s byp_data%0d", tag, r), rd_data_b[r], exp_data(rd_addr[r], 1'b1));
            chk($sformatf("%s nb_data%0d",  tag, r), rd_data_n[r], exp_data(rd_addr[r], 1'b0));
            chk($sformatf("%s byp_busy%0d", tag, r), {31'b0, rd_busy_b[r]}, {31'b0, exp_busy(rd_addr[r], 1'b1)});
            chk($sformatf("%s nb_busy%0d",  tag, r), {31'b0, rd_busy_n[r]}, {31'b0, exp_busy(rd_addr[r], 1'b0)});
        end
    endtask

    task automatic idle();
        for (int w = 0; w < NW; w++) begin
            wr_en[w]    = 1'b0;
            wr_addr[w]  = '0;
            wr_data[w]  = '0;
            rsv_en[w]   = 1'b0;
            rsv_addr[w] = '0;
            wr_pc[w]    = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a write and reservation presented: both must be ignored.
        rst_n = 1'b0;
        model_reset();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
        rsv_en[0] = 1'b1; rsv_addr[0] = 5'd6;
        for (int r = 0; r < NR; r++) rd_addr[r] = 5'd5;
        rd_addr[1] = 5'd6;
        #1;
        check_all("in_reset");
        chk("reset_fwd_blocked", rd_data_b[0], 32'h0);
        step();
        step();
        rst_n = 1'b1;
        idle();
        #1;
        check_all("after_reset");
        chk("reset_write_ignored", rd_data_b[0], 32'h0);
        chk("reset_rsv_ignored", {31'b0, rd_busy_b[1]}, 32'h0);

        // Plain write, read on the next cycle.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'h1234_5678; wr_pc[0] = 32'h0040_0000;
        rd_addr[3] = 5'd1;
        #1;
        check_all("w5");
        step();
        idle();
        rd_addr[3] = 5'd5;
        #1;
        chk("r5_data", rd_data_b[3], 32'h1234_5678);
        chk("r5_busy", {31'b0, rd_busy_b[3]}, 32'h0);
        check_all("r5");

        // Same-cycle write and read: forwarded only with bypass.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hAAAA_0000;
        for (int r = 0; r < NR; r++) rd_addr[r] = 5'd7;
        #1;
        chk("fwd7_byp", rd_data_b[0], 32'hAAAA_0000);
        chk("fwd7_nb_old", rd_data_n[0], 32'h0);
        check_all("fwd7");
        step();
        idle();
        #1;
        chk("fwd7_nb_next", rd_data_n[0], 32'hAAAA_0000);
        check_all("fwd7_next");

        // Two ports write one register: the higher port wins.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h1;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h2;
        rd_addr[1] = 5'd9;
        #1;
        chk("dual9_fwd", rd_data_b[1], 32'h2);
        step();
        idle();
        #1;
        chk("dual9_byp", rd_data_b[1], 32'h2);
        chk("dual9_nb", rd_data_n[1], 32'h2);
        check_all("dual9");

        // Reservation, stall, writeback, then set-over-clear on one edge.
        rsv_en[0] = 1'b1; rsv_addr[0] = 5'd3;
        rd_addr[2] = 5'd3;
        #1;
        chk("rsv3_same_cycle", {31'b0, rd_busy_b[2]}, 32'h0);
        step();
        idle();
        #1;
        chk("rsv3_busy", {31'b0, rd_busy_b[2]}, 32'h1);
        step();
        #1;
        chk("rsv3_still_busy", {31'b0, rd_busy_n[2]}, 32'h1);
        wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
        #1;
        chk("wb3_byp_busy", {31'b0, rd_busy_b[2]}, 32'h0);
        chk("wb3_nb_busy", {31'b0, rd_busy_n[2]}, 32'h1);
        chk("wb3_byp_data", rd_data_b[2], 32'h33);
        check_all("wb3");
        step();
        idle();
        #1;
        chk("wb3_cleared", {31'b0, rd_busy_n[2]}, 32'h0);
        wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h44;
        rsv_en[1] = 1'b1; rsv_addr[1] = 5'd3;
        step();
        idle();
        #1;
        chk("set_wins_byp", {31'b0, rd_busy_b[2]}, 32'h1);
        chk("set_wins_nb", {31'b0, rd_busy_n[2]}, 32'h1);
        chk("set_wins_data", rd_data_b[2], 32'h44);

        // Register 0 ignores writes and reservations.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
        rsv_en[0] = 1'b1; rsv_addr[0] = 5'd0;
        for (int r = 0; r < NR; r++) rd_addr[r] = 5'd0;
        #1;
        chk("r0_fwd", rd_data_b[0], 32'h0);
        check_all("r0_same");
        step();
        idle();
        #1;
        chk("r0_data", rd_data_b[0], 32'h0);
        chk("r0_busy", {31'b0, rd_busy_b[0]}, 32'h0);

        // Mid-cycle asynchronous reset discards data and busy state.
        wr_en[1] = 1'b1; wr_addr[1] = 5'd4; wr_data[1] = 32'h55;
        step();
        idle();
        rsv_en[0] = 1'b1; rsv_addr[0] = 5'd4;
        step();
        idle();
        rd_addr[0] = 5'd4;
        #1;
        chk("r4_pre_data", rd_data_b[0], 32'h55);
        chk("r4_pre_busy", {31'b0, rd_busy_b[0]}, 32'h1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("r4_rst_data", rd_data_b[0], 32'h0);
        chk("r4_rst_busy", {31'b0, rd_busy_b[0]}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("r4_post_data", rd_data_b[0], 32'h0);
        chk("r4_post_busy", {31'b0, rd_busy_n[0]}, 32'h0);
        check_all("r4_post");
        step();

        // Random traffic over a small register window to force collisions.
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < NW; w++) begin
                wr_en[w]    = 1'($urandom_range(0, 1));
                wr_addr[w]  = reg_idx_t'($urandom_range(0, 7));
                wr_data[w]  = $urandom;
                wr_pc[w]    = $urandom;
                rsv_en[w]   = ($urandom_range(0, 2) == 0);
                rsv_addr[w] = reg_idx_t'($urandom_range(0, 7));
            end
            for (int r = 0; r < NR; r++) begin
                rd_addr[r] = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31))
                                                         : reg_idx_t'($urandom_range(0, 7));
            end
            #1;
            check_all($sformatf("rand%0d", c));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter NUM_READ, default 4, number of read ports (1..8).
REQ-002 SHALL have parameter NUM_WRITE, default 2, number of write/reserve port pairs (1..4).
REQ-003 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-004 SHALL have parameter NUM_REGS, default 32, register count; power of two; AW = clog2(NUM_REGS).
REQ-005 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding in the same cycle.
REQ-006 SHALL have parameter TRACE_EN, default 0, which enables the simulation-only write trace.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state on rising edge; this block has one clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have ports rd_addr[NUM_READ], input, AW bits each: read register index.
REQ-010 SHALL have ports rd_data[NUM_READ], output, DATA_W bits each: read value.
REQ-011 SHALL have ports rd_busy[NUM_READ], output, 1 bit each: the addressed register has a pending producer.
REQ-012 SHALL have ports wr_en/wr_addr/wr_data[NUM_WRITE], input, 1/AW/DATA_W bits: writeback.
REQ-013 SHALL have ports rsv_en/rsv_addr[NUM_WRITE], input, 1/AW bits: issue-time reservation that marks the destination busy.
REQ-014 SHALL have ports wr_pc[NUM_WRITE], input, 32 bits: used for the trace only.

Function
REQ-015 SHALL treat register 0 as constant zero: reads return 0 and rd_busy=0; writes and reservations to index 0 are ignored.
REQ-016 SHALL make reads combinational: rd_data = stored value, or forwarded value per REQ-017.
REQ-017 With BYPASS=1, SHALL drive rd_data from the highest-indexed write port whose wr_en=1 and wr_addr equals rd_addr, same cycle.
REQ-018 With BYPASS=0, SHALL return the pre-edge stored value on rd_data; the write becomes visible the cycle after.
REQ-019 SHALL resolve same-cycle writes to one address so the highest-indexed write port wins; the other writes are dropped.
REQ-020 SHALL keep a busy bit per register: a rising edge with rsv_en sets the bit; a rising edge with wr_en clears it.
REQ-021 SHALL give set priority when a set and a clear hit the same register on the same edge (a new producer supersedes the old one).
REQ-022 SHALL drive rd_busy = busy[rd_addr] AND NOT(BYPASS AND a same-cycle write to rd_addr).
REQ-023 SHALL still update data when a write targets a non-busy register, with no error flag.
REQ-024 With TRACE_EN=1, SHALL print one line per accepted write on the falling clock edge while out of reset, format "@<pc hex>: $<idx> <= <data hex>"; writes to register 0 are not printed.

Reset
REQ-025 SHALL asynchronously clear all registers and all busy bits to 0 when rst_n is low.
REQ-026 SHALL force rd_data to 0 and rd_busy to 0 on every port during reset.
REQ-027 SHALL ignore writes and reservations presented while rst_n is low; a reset in the middle of operation discards pending state.
REQ-028 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the register index typedef, the AW helper and the parameter defaults in the shared Mips definitions package.
REQ-030 SHALL implement the busy-bit logic (REQ-020..022) as the sub-module reg_scoreboard, parameterised by NUM_REGS, NUM_READ and NUM_WRITE.
REQ-031 SHALL keep the data array and forwarding mux in the top module; no latches; the trace logic is excluded from synthesis.

Verification
REQ-032 SHALL cover: write port 0 $5=0x12345678, next cycle read port 3 of $5 -> 0x12345678, rd_busy=0.
REQ-033 SHALL cover: BYPASS=1, same-cycle write $7=0xAAAA0000 and read of $7 -> rd_data=0xAAAA0000 in that cycle; with BYPASS=0 the same stimulus -> old value, and the new value the next cycle.
REQ-034 SHALL cover: port 0 writes $9=0x1 and port 1 writes $9=0x2 on one edge -> $9 reads 0x2.
REQ-035 SHALL cover: reserve $3, then read $3 -> rd_busy=1 until the writeback edge; on the writeback cycle rd_busy=0 (BYPASS=1); on one edge reserve $3 on port 1 with writeback $3 on port 0 -> busy stays 1.
REQ-036 SHALL cover: write $0=0xFFFFFFFF and reserve $0 -> reads return 0, rd_busy=0, no trace line.
REQ-037 SHALL cover: $4=0x55 and $4 busy, then rst_n pulsed low mid-cycle (no clk edge) -> $4 reads 0 and rd_busy=0 immediately.
